// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store in flight, fixed wait states,
// byte-enabled stores, misaligned/out-of-range error flagging.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);
  localparam logic [3:0] WLOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           write_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     be_q;
  logic [31:0]    rdata_q;
  logic           error_q;
  logic [CNT_WIDTH-1:0] rd_q, wr_q, er_q;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           a_write;
  logic [31:0]    a_addr;
  logic [31:0]    a_wdata;
  logic [3:0]     a_be;
  logic           a_err;
  logic [AW-1:0]  a_idx;
  logic           accept;
  logic           access;
  logic           hs;

  // Zero-wait builds access straight from the request port.
  always_comb begin
    a_write = write_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_be    = be_q;
    if (state_q == S_IDLE) begin
      a_write = req_write;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
    end
  end

  assign a_err  = (|a_addr[1:0]) || (a_addr[31:2] >= DEPTH30);
  assign a_idx  = a_addr[AW+1:2];
  assign accept = (state_q == S_IDLE) && req_valid;
  assign access = (accept && (WAIT_STATES == 0)) ||
                  ((state_q == S_WAIT) && (wcnt_q == 4'd0));
  assign hs     = (state_q == S_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WLOAD;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_RESP;
        else wcnt_d = wcnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WAIT: ;
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      er_q    <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (access) begin
        error_q <= a_err;
        rdata_q <= (!a_write && !a_err) ? mem_q[a_idx] : '0;
      end
      if (hs) begin
        rdata_q <= '0;
        error_q <= 1'b0;
        if (error_q) begin
          if (er_q != '1) er_q <= er_q + 1'b1;
        end else if (write_q) begin
          if (wr_q != '1) wr_q <= wr_q + 1'b1;
        end else begin
          if (rd_q != '1) rd_q <= rd_q + 1'b1;
        end
      end
    end
  end

  // Array has no reset; a reset edge must not let a pending store land.
  always_ff @(posedge clk) begin
    if (!reset && access && a_write && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = er_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: main build (2 wait states) plus a zero-wait,
// 4-bit-counter build for throughput and saturation.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [15:0] rd_count, wr_count, err_count;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_error;
  logic [31:0] z_rsp_rdata;
  logic        z_busy;
  logic [3:0]  z_rd_count, z_wr_count, z_err_count;

  int n_run  = 0;
  int n_fail = 0;

  assign z_rsp_ready = 1'b1;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(256), .WAIT_STATES(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .rd_count(rd_count),
    .wr_count(wr_count), .err_count(err_count)
  );

  data_mem_responder #(
    .DEPTH_WORDS(256), .WAIT_STATES(0), .CNT_WIDTH(4)
  ) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error),
    .busy(z_busy), .rd_count(z_rd_count),
    .wr_count(z_wr_count), .err_count(z_err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  task automatic txn(input logic wr,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] be,
                     output logic [31:0] rd,
                     output logic err,
                     output int lat);
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
    chk("rsp_seen", rsp_valid, 1);
    rd  = rsp_rdata;
    err = rsp_error;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0;
    req_wdata = 0; req_be = 0; rsp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0;
    z_req_wdata = 0; z_req_be = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_error", rsp_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", {rd_count, wr_count} | 32'(err_count), 0);
    reset = 1'b0;

    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
    chk("st_lat", lat, 3);
    chk("st_rdata", rd, 0);
    chk("st_err", err, 0);
    chk("st_wr_count", wr_count, 1);

    txn(0, 32'h10, 0, 0, rd, err, lat);
    chk("ld_lat", lat, 3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", err, 0);
    chk("ld_rd_count", rd_count, 1);

    txn(1, 32'h10, 32'h11223344, 4'b0101, rd, err, lat);
    chk("be_st_err", err, 0);
    txn(0, 32'h10, 0, 0, rd, err, lat);
    chk("be_merge", rd, 32'hDE22BE44);

    txn(1, 32'h0, 32'h12345678, 4'hF, rd, err, lat);
    txn(1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, err, lat);
    chk("be0_err", err, 0);
    txn(0, 32'h10, 0, 0, rd, err, lat);
    chk("be0_nochange", rd, 32'hDE22BE44);

    txn(0, 32'h12, 0, 0, rd, err, lat);
    chk("mis_err", err, 1);
    chk("mis_rdata", rd, 0);
    txn(1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    chk("oor_err", err, 1);
    chk("oor_rdata", rd, 0);
    txn(0, 32'h0, 0, 0, rd, err, lat);
    chk("word0_kept", rd, 32'h12345678);
    chk("err_count", err_count, 2);
    chk("rd_count4", rd_count, 4);
    chk("wr_count4", wr_count, 4);

    // backpressure with req_valid held high throughout
    @(negedge clk);
    req_write = 0; req_addr = 32'h10; req_valid = 1'b1;
    @(negedge clk);
    req_addr = 32'h0;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'hDE22BE44);
      chk("bp_err", rsp_error, 0);
      chk("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_rdata", rsp_rdata, 0);
    chk("bp_rd_count", rd_count, 5);
    @(negedge clk);
    chk("bp_2nd_busy", busy, 1);
    chk("bp_2nd_ready", req_ready, 0);
    req_valid = 1'b0;
    wait_rsp();
    chk("bp_2nd_rdata", rsp_rdata, 32'h12345678);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_rd_count2", rd_count, 6);

    // reset during WAIT discards the pending store
    txn(1, 32'h20, 32'hAAAA5555, 4'hF, rd, err, lat);
    @(negedge clk);
    req_write = 1; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rd_count", rd_count, 0);
    chk("mid_wr_count", wr_count, 0);
    chk("mid_err_count", err_count, 0);
    txn(0, 32'h20, 0, 0, rd, err, lat);
    chk("mid_prior", rd, 32'hAAAA5555);

    // zero-wait build, rsp_ready tied high
    @(negedge clk);
    chk("z_idle_ready", z_req_ready, 1);
    z_req_write = 1; z_req_addr = 32'h8;
    z_req_wdata = 32'h0BADF00D; z_req_be = 4'hF; z_req_valid = 1'b1;
    @(negedge clk);
    chk("z_st_valid", z_rsp_valid, 1);
    chk("z_st_err", z_rsp_error, 0);
    @(negedge clk);
    chk("z_st_idle", z_req_ready, 1);
    chk("z_wr_count", z_wr_count, 1);
    z_req_write = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("z_ld_valid", z_rsp_valid, 1);
      chk("z_ld_rdata", z_rsp_rdata, 32'h0BADF00D);
      @(negedge clk);
      chk("z_ld_idle", z_req_ready, 1);
      chk("z_ld_novalid", z_rsp_valid, 0);
      chk("z_rd_count", z_rd_count, (i < 15) ? i + 1 : 15);
    end
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_rd_sat", z_rd_count, 15);
    chk("z_wr_final", z_wr_count, 1);
    chk("z_err_final", z_err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
